// File: rtl/microcode_sequencer_if.sv
// Micro-op type shared by the sequencer, its micro-ROM and the decoder,
// plus the bus interface between the sequencer and its environment.
// The master modport is the sequencer side; the slave modport is the ROM/CPU side.

package microcode_pkg;

  typedef enum logic [5:0] {
    ENDMICRO   = 6'd0,
    PC_to_MAR  = 6'd1,
    RAM_to_IR  = 6'd2,
    INC_PC     = 6'd3,
    HLT_CLK    = 6'd4,
    WAIT_GPU   = 6'd5,
    WAIT_DD    = 6'd6,
    WAIT_MT    = 6'd7,
    WAIT_UT    = 6'd8,
    WAIT_FT    = 6'd9,
    START_GPU  = 6'd10,
    START_DD   = 6'd11,
    START_MT   = 6'd12,
    START_UT   = 6'd13,
    START_FT   = 6'd14,
    RAM_to_A   = 6'd15,
    A_to_B     = 6'd16,
    B_to_A     = 6'd17,
    A_to_RAM   = 6'd18,
    ALU_ADD    = 6'd19,
    ALU_SUB    = 6'd20,
    A_to_MAR   = 6'd21
  } Microcode_enum;

endpackage

interface microcode_sequencer_if #(
  parameter int OPCODE_W = 8,
  parameter int STEP_W   = 4
);
  import microcode_pkg::*;

  logic [OPCODE_W-1:0]        opcode;
  Microcode_enum              rom_uop;
  logic                       gpu_busy;
  logic                       dd_busy;
  logic                       ms_busy;
  logic                       us_busy;
  logic                       ft_busy;
  logic                       resume;
  logic [OPCODE_W+STEP_W-1:0] rom_addr;
  Microcode_enum              current_microcode;
  logic                       in_fetch;
  logic                       halted;
  logic                       ucode_overflow;
  logic                       wdog_err;

  modport master (
    input  opcode, rom_uop, gpu_busy, dd_busy, ms_busy, us_busy, ft_busy, resume,
    output rom_addr, current_microcode, in_fetch, halted, ucode_overflow, wdog_err
  );

  modport slave (
    output opcode, rom_uop, gpu_busy, dd_busy, ms_busy, us_busy, ft_busy, resume,
    input  rom_addr, current_microcode, in_fetch, halted, ucode_overflow, wdog_err
  );

endinterface

// File: rtl/microcode_sequencer.sv
// Microcode sequencer: hard-wired three-cycle fetch (F0..F2) followed by
// execute steps read from an external combinational micro-ROM at {opcode, step}.
// WAIT_* micro-ops stall until the matching unit is idle; HLT_CLK parks the
// sequencer in HALT until resume. A step wrap without ENDMICRO sets the sticky
// ucode_overflow flag.
// Optional feature macro: SEQ_WATCHDOG_EN -- bounds a single stall to
// WDOG_CYCLES cycles, abandons the instruction and sets the sticky wdog_err.

module microcode_sequencer
  import microcode_pkg::*;
#(
  parameter int OPCODE_W    = 8,
  parameter int STEP_W      = 4,
  parameter int WDOG_CYCLES = 4096
) (
  input  logic                     clk,
  input  logic                     n_rst,
  microcode_sequencer_if.master    bus
);

  typedef enum logic [2:0] {
    S_RST  = 3'd0,
    S_F0   = 3'd1,
    S_F1   = 3'd2,
    S_F2   = 3'd3,
    S_EXEC = 3'd4,
    S_HALT = 3'd5
  } state_t;

  localparam logic [STEP_W-1:0] STEP_MAX  = {STEP_W{1'b1}};
  localparam logic [STEP_W-1:0] STEP_ZERO = {STEP_W{1'b0}};

  state_t              r_state;
  state_t              w_state_nxt;
  logic [STEP_W-1:0]   r_step;
  logic [STEP_W-1:0]   w_step_nxt;
  logic                r_ovf;
  logic                w_ovf_nxt;
  logic                w_is_wait;
  logic                w_wait_busy;
  logic                w_stall;
  logic                w_wdog_trip;

  // Pick the busy flag belonging to the current WAIT_* op; other flags are never looked at
  always_comb begin
    w_is_wait   = 1'b0;
    w_wait_busy = 1'b0;
    case (bus.rom_uop)
      WAIT_GPU: begin w_is_wait = 1'b1; w_wait_busy = bus.gpu_busy; end
      WAIT_DD:  begin w_is_wait = 1'b1; w_wait_busy = bus.dd_busy;  end
      WAIT_MT:  begin w_is_wait = 1'b1; w_wait_busy = bus.ms_busy;  end
      WAIT_UT:  begin w_is_wait = 1'b1; w_wait_busy = bus.us_busy;  end
      WAIT_FT:  begin w_is_wait = 1'b1; w_wait_busy = bus.ft_busy;  end
      default:  begin w_is_wait = 1'b0; w_wait_busy = 1'b0;         end
    endcase
  end

  // A stall only exists while a WAIT_* op is actually being executed
  assign w_stall = (r_state == S_EXEC) && w_is_wait && w_wait_busy;

`ifdef SEQ_WATCHDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

  logic [WDOG_W-1:0] r_wdog_cnt;
  logic              r_wdog_err;

  // Trip on the WDOG_CYCLES-th consecutive stalled cycle of one WAIT
  assign w_wdog_trip = w_stall && (r_wdog_cnt == WDOG_W'(WDOG_CYCLES - 1));

  // Stall length counter and sticky watchdog flag
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_wdog_cnt <= {WDOG_W{1'b0}};
      r_wdog_err <= 1'b0;
    end else if (w_wdog_trip) begin
      r_wdog_cnt <= {WDOG_W{1'b0}};
      r_wdog_err <= 1'b1;
    end else if (w_stall) begin
      r_wdog_cnt <= r_wdog_cnt + WDOG_W'(1);
    end else begin
      r_wdog_cnt <= {WDOG_W{1'b0}};
    end
  end

  assign bus.wdog_err = r_wdog_err;
`else
  logic w_unused_wdog;

  // Without the watchdog a stall lasts as long as the unit stays busy
  assign w_wdog_trip   = 1'b0;
  assign w_unused_wdog = (WDOG_CYCLES == 0);
  assign bus.wdog_err  = 1'b0;
`endif

  // State, step and sticky overflow registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= S_RST;
      r_step  <= STEP_ZERO;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_step  <= w_step_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  // Next-state and step sequencing
  always_comb begin
    w_state_nxt = r_state;
    w_step_nxt  = r_step;
    w_ovf_nxt   = r_ovf;
    case (r_state)
      S_RST: begin
        w_state_nxt = S_F0;
        w_step_nxt  = STEP_ZERO;
      end
      S_F0: begin
        w_state_nxt = S_F1;
      end
      S_F1: begin
        w_state_nxt = S_F2;
      end
      S_F2: begin
        w_state_nxt = S_EXEC;
        w_step_nxt  = STEP_ZERO;
      end
      S_EXEC: begin
        if (bus.rom_uop == ENDMICRO) begin
          w_state_nxt = S_F0;
          w_step_nxt  = STEP_ZERO;
        end else if (bus.rom_uop == HLT_CLK) begin
          w_state_nxt = S_HALT;
          w_step_nxt  = STEP_ZERO;
        end else if (w_wdog_trip) begin
          // Abandon the stuck instruction and fetch the next one
          w_state_nxt = S_F0;
          w_step_nxt  = STEP_ZERO;
        end else if (w_stall) begin
          w_step_nxt  = r_step;
        end else if (r_step == STEP_MAX) begin
          // Last step executed without ENDMICRO: wrap to fetch and flag it
          w_state_nxt = S_F0;
          w_step_nxt  = STEP_ZERO;
          w_ovf_nxt   = 1'b1;
        end else begin
          w_step_nxt  = r_step + STEP_W'(1);
        end
      end
      S_HALT: begin
        if (bus.resume) begin
          w_state_nxt = S_F0;
          w_step_nxt  = STEP_ZERO;
        end else begin
          w_state_nxt = S_HALT;
        end
      end
      default: begin
        w_state_nxt = S_RST;
        w_step_nxt  = STEP_ZERO;
      end
    endcase
  end

  // Micro-op and status outputs decoded from state (EXEC passes the ROM through)
  always_comb begin
    bus.current_microcode = ENDMICRO;
    bus.in_fetch          = 1'b0;
    bus.halted            = 1'b0;
    case (r_state)
      S_F0: begin
        bus.current_microcode = PC_to_MAR;
        bus.in_fetch          = 1'b1;
      end
      S_F1: begin
        bus.current_microcode = RAM_to_IR;
        bus.in_fetch          = 1'b1;
      end
      S_F2: begin
        bus.current_microcode = INC_PC;
        bus.in_fetch          = 1'b1;
      end
      S_EXEC: begin
        bus.current_microcode = bus.rom_uop;
      end
      S_HALT: begin
        bus.current_microcode = HLT_CLK;
        bus.halted            = 1'b1;
      end
      default: begin
        bus.current_microcode = ENDMICRO;
      end
    endcase
  end

  assign bus.rom_addr       = {bus.opcode, r_step};
  assign bus.ucode_overflow = r_ovf;

endmodule
